// File: rtl/serial_tx_pkg.sv
// Shared types and widths for the serial word transmitter.
package serial_tx_pkg;
   localparam int WORD_W    = 24;
   localparam int BIT_CNT_W = 5;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      GAP   = 2'd2
   } tx_state_t;
endpackage

// File: rtl/shift_reg_w.sv
// Parallel-load, shift-left register; the MSB is the serial output.
module shift_reg_w
   import serial_tx_pkg::*;
#(
   parameter int WIDTH = WORD_W
) (
   input  logic             Clk,
   input  logic             Reset,
   input  logic             load,
   input  logic             shift_en,
   input  logic [WIDTH-1:0] load_data,
   input  logic             ser_in,
   output logic             ser_out
);

   logic [WIDTH-1:0] data_q;

   always_ff @(posedge Clk) begin
      if (Reset) begin
         data_q <= '0;
      end else if (load) begin
         data_q <= load_data;
      end else if (shift_en) begin
         data_q <= {data_q[WIDTH-2:0], ser_in};
      end
   end

   assign ser_out = data_q[WIDTH-1];

endmodule

// File: rtl/serial_tx_ctrl.sv
// Serialises 24-bit words MSB-first onto SCLK/SDATA/CS_N with a fixed inter-frame gap.
//   state | meaning
//   IDLE  | waiting for a word, in_ready high
//   SHIFT | frame in progress, cs_n low, sclk running
//   GAP   | cs_n high for GAP_CYCLES clocks before accepting again
module serial_tx_ctrl
   import serial_tx_pkg::*;
#(
   parameter int CLK_DIV    = 4,
   parameter int GAP_CYCLES = 2
) (
   input  logic              Clk,
   input  logic              Reset,
   input  logic              in_valid,
   input  logic [WORD_W-1:0] in_data,
   output logic              in_ready,
   output logic              sclk,
   output logic              sdata,
   output logic              cs_n,
   output logic              busy,
   output logic              done
);

   localparam int DIV_W = $clog2(CLK_DIV) + 1;
   localparam int GAP_W = $clog2(GAP_CYCLES) + 1;
   localparam logic [DIV_W-1:0]     DIV_LAST = DIV_W'(CLK_DIV - 1);
   localparam logic [GAP_W-1:0]     GAP_LAST = GAP_W'(GAP_CYCLES - 1);
   localparam logic [BIT_CNT_W-1:0] BIT_LAST = BIT_CNT_W'(WORD_W - 1);

   tx_state_t            state;
   logic [DIV_W-1:0]     div_cnt;
   logic [BIT_CNT_W-1:0] bit_cnt;
   logic [GAP_W-1:0]     gap_cnt;
   logic                 sclk_q;
   logic                 cs_n_q;
   logic                 done_q;
   logic                 in_ready_q;
   logic                 transfer;
   logic                 bit_end;

   assign transfer = (state == IDLE) && in_valid && in_ready_q;
   // A bit ends on the last divider count of the sclk-high half.
   assign bit_end  = (state == SHIFT) && (div_cnt == DIV_LAST) && sclk_q;

   always_ff @(posedge Clk) begin
      if (Reset) begin
         state      <= IDLE;
         div_cnt    <= '0;
         bit_cnt    <= '0;
         gap_cnt    <= '0;
         sclk_q     <= 1'b0;
         cs_n_q     <= 1'b1;
         done_q     <= 1'b0;
         in_ready_q <= 1'b0;
      end else begin
         done_q <= 1'b0;
         case (state)
            IDLE: begin
               in_ready_q <= 1'b1;
               sclk_q     <= 1'b0;
               cs_n_q     <= 1'b1;
               if (transfer) begin
                  state      <= SHIFT;
                  in_ready_q <= 1'b0;
                  cs_n_q     <= 1'b0;
                  div_cnt    <= '0;
                  bit_cnt    <= '0;
               end
            end
            SHIFT: begin
               if (div_cnt == DIV_LAST) begin
                  div_cnt <= '0;
                  sclk_q  <= ~sclk_q;
                  if (sclk_q) begin
                     if (bit_cnt == BIT_LAST) begin
                        state   <= GAP;
                        done_q  <= 1'b1;
                        cs_n_q  <= 1'b1;
                        gap_cnt <= GAP_LAST;
                     end else begin
                        bit_cnt <= bit_cnt + BIT_CNT_W'(1);
                     end
                  end
               end else begin
                  div_cnt <= div_cnt + DIV_W'(1);
               end
            end
            GAP: begin
               if (gap_cnt == '0) begin
                  state      <= IDLE;
                  in_ready_q <= 1'b1;
               end else begin
                  gap_cnt <= gap_cnt - GAP_W'(1);
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   shift_reg_w #(.WIDTH(WORD_W)) u_shift (
      .Clk       (Clk),
      .Reset     (Reset),
      .load      (transfer),
      .shift_en  (bit_end),
      .load_data (in_data),
      .ser_in    (1'b0),
      .ser_out   (sdata)
   );

   assign in_ready = in_ready_q;
   assign sclk     = sclk_q;
   assign cs_n     = cs_n_q;
   assign done     = done_q;
   assign busy     = (state != IDLE);

endmodule

// File: tb/tb_serial_tx_ctrl.sv
// Scoreboard bench: stimulus queues expected frames, negedge monitors rebuild and compare them.
module tb_serial_tx_ctrl;

   typedef struct {
      logic [23:0] word;
      bit          aborted;
   } exp_t;

   logic        Clk = 1'b0;
   logic        Reset = 1'b1;
   logic        in_valid = 1'b0;
   logic [23:0] in_data = '0;
   logic        in_ready, sclk, sdata, cs_n, busy, done;

   logic        f_valid = 1'b0;
   logic [23:0] f_data = '0;
   logic        f_ready, f_sclk, f_sdata, f_cs_n, f_busy, f_done;

   int n_cmp = 0;
   int n_err = 0;
   int cyc = 0;

   exp_t mq[$];
   exp_t fq[$];

   int          m_low = 0, m_bits = 0, m_stray = 0, m_dones = 0, m_done_cyc = 0;
   logic [23:0] m_word = '0;
   logic        m_prev_sclk = 1'b0, m_prev_cs = 1'b1;

   int          f_low = 0, f_bits = 0, f_tog_err = 0, f_dones = 0;
   logic [23:0] f_word = '0;
   logic        f_prev_sclk = 1'b0, f_prev_cs = 1'b1;

   serial_tx_ctrl dut (
      .Clk(Clk), .Reset(Reset), .in_valid(in_valid), .in_data(in_data),
      .in_ready(in_ready), .sclk(sclk), .sdata(sdata), .cs_n(cs_n),
      .busy(busy), .done(done)
   );

   serial_tx_ctrl #(.CLK_DIV(1), .GAP_CYCLES(1)) dut_fast (
      .Clk(Clk), .Reset(Reset), .in_valid(f_valid), .in_data(f_data),
      .in_ready(f_ready), .sclk(f_sclk), .sdata(f_sdata), .cs_n(f_cs_n),
      .busy(f_busy), .done(f_done)
   );

   initial forever #5 Clk = ~Clk;
   initial forever begin
      @(posedge Clk);
      cyc++;
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Main-instance monitor: rebuild each frame from bits seen on sclk rising edges.
   initial begin
      exp_t e;
      forever begin
         @(negedge Clk);
         if (cs_n === 1'b0) begin
            if (m_prev_cs !== 1'b0) begin
               m_low = 0; m_bits = 0; m_word = '0;
            end
            m_low++;
            if (sclk === 1'b1 && m_prev_sclk === 1'b0) begin
               m_word = {m_word[22:0], sdata};
               m_bits++;
            end
         end else begin
            if (sclk === 1'b1 && m_prev_sclk === 1'b0) m_stray++;
            if (m_prev_cs === 1'b0) begin
               if (mq.size() == 0) begin
                  chk("extra_frame", 32'd1, 32'd0);
               end else begin
                  e = mq.pop_front();
                  if (e.aborted) begin
                     chk("abort_no_done", {31'd0, done}, 32'd0);
                     chk("abort_bits", m_bits, 32'd10);
                  end else begin
                     chk("frame_word", {8'd0, m_word}, {8'd0, e.word});
                     chk("frame_bits", m_bits, 32'd24);
                     chk("cs_low_clocks", m_low, 32'd192);
                     chk("done_at_frame_end", {31'd0, done}, 32'd1);
                  end
               end
            end
         end
         if (done === 1'b1) begin
            m_dones++;
            m_done_cyc = cyc;
         end
         m_prev_sclk = sclk;
         m_prev_cs   = cs_n;
      end
   end

   // Fast-instance monitor (CLK_DIV=1, GAP_CYCLES=1).
   initial begin
      exp_t e;
      forever begin
         @(negedge Clk);
         if (f_cs_n === 1'b0) begin
            if (f_prev_cs !== 1'b0) begin
               f_low = 0; f_bits = 0; f_word = '0; f_tog_err = 0;
            end else if (f_sclk === f_prev_sclk) begin
               f_tog_err++;
            end
            f_low++;
            if (f_sclk === 1'b1 && f_prev_sclk === 1'b0) begin
               f_word = {f_word[22:0], f_sdata};
               f_bits++;
            end
         end else if (f_prev_cs === 1'b0) begin
            if (fq.size() == 0) begin
               chk("fast_extra_frame", 32'd1, 32'd0);
            end else begin
               e = fq.pop_front();
               chk("fast_frame_word", {8'd0, f_word}, {8'd0, e.word});
               chk("fast_frame_clocks", f_low, 32'd48);
               chk("fast_sclk_toggle", f_tog_err, 32'd0);
               chk("fast_done_at_end", {31'd0, f_done}, 32'd1);
            end
         end
         if (f_done === 1'b1) f_dones++;
         f_prev_sclk = f_sclk;
         f_prev_cs   = f_cs_n;
      end
   end

   task automatic send(input logic [23:0] w, input bit keep, input bit ab, output int acc);
      int n;
      exp_t e;
      in_valid = 1'b1;
      in_data  = w;
      n = 0;
      while (in_ready !== 1'b1 && n < 2000) begin
         @(negedge Clk);
         n++;
      end
      if (n >= 2000) chk("accept_timeout", 32'd0, 32'd1);
      acc = cyc + 1;
      e.word = w;
      e.aborted = ab;
      mq.push_back(e);
      @(negedge Clk);
      if (!keep) in_valid = 1'b0;
   endtask

   task automatic fsend(input logic [23:0] w, input bit keep, output int acc);
      int n;
      exp_t e;
      f_valid = 1'b1;
      f_data  = w;
      n = 0;
      while (f_ready !== 1'b1 && n < 2000) begin
         @(negedge Clk);
         n++;
      end
      if (n >= 2000) chk("fast_accept_timeout", 32'd0, 32'd1);
      acc = cyc + 1;
      e.word = w;
      e.aborted = 1'b0;
      fq.push_back(e);
      @(negedge Clk);
      if (!keep) f_valid = 1'b0;
   endtask

   task automatic wait_cyc(input int t);
      while (cyc < t) @(negedge Clk);
   endtask

   initial begin
      int a0, a1, a2, a3, a4, fa1, fa2, n;

      repeat (3) @(negedge Clk);
      chk("rst_cs_n", {31'd0, cs_n}, 32'd1);
      chk("rst_sclk", {31'd0, sclk}, 32'd0);
      chk("rst_sdata", {31'd0, sdata}, 32'd0);
      chk("rst_done", {31'd0, done}, 32'd0);
      chk("rst_in_ready", {31'd0, in_ready}, 32'd0);
      chk("rst_busy", {31'd0, busy}, 32'd0);
      Reset = 1'b0;
      @(negedge Clk);
      chk("ready_after_reset", {31'd0, in_ready}, 32'd1);

      send(24'hA5C3F0, 1'b0, 1'b0, a0);
      send(24'hFFFFFF, 1'b1, 1'b0, a1);
      chk("done_latency", m_done_cyc - a0, 32'd192);
      send(24'h000001, 1'b0, 1'b0, a2);
      chk("accept_after_done", a2 - m_done_cyc, 32'd3);
      chk("b2b_period", a2 - a1, 32'd195);

      n = 0;
      while (!(in_ready === 1'b1 && busy === 1'b0) && n < 1000) begin
         @(negedge Clk);
         n++;
      end
      chk("idle_before_abort", {31'd0, in_ready}, 32'd1);

      send(24'h777777, 1'b0, 1'b1, a3);
      wait_cyc(a3 + 81);
      Reset = 1'b1;
      @(negedge Clk);
      chk("abort_cs_n", {31'd0, cs_n}, 32'd1);
      chk("abort_sclk", {31'd0, sclk}, 32'd0);
      chk("abort_sdata", {31'd0, sdata}, 32'd0);
      chk("abort_done", {31'd0, done}, 32'd0);
      Reset = 1'b0;
      @(negedge Clk);
      chk("ready_after_abort", {31'd0, in_ready}, 32'd1);

      send(24'h123456, 1'b0, 1'b0, a4);
      wait_cyc(a4 + 50);
      in_valid = 1'b1;
      in_data  = 24'hDEAD00;
      @(negedge Clk);
      in_valid = 1'b0;
      wait_cyc(a4 + 192);
      chk("gap_pulse_done", {31'd0, done}, 32'd1);
      in_valid = 1'b1;
      in_data  = 24'hDEAD00;
      @(negedge Clk);
      in_valid = 1'b0;
      repeat (300) @(negedge Clk);
      chk("queue_drained", mq.size(), 32'd0);
      chk("done_count", m_dones, 32'd4);
      chk("stray_sclk", m_stray, 32'd0);
      chk("idle_after_pulses", {31'd0, busy}, 32'd0);

      fsend(24'h5A5A5A, 1'b1, fa1);
      fsend(24'hC3C3C3, 1'b0, fa2);
      chk("fast_word_period", fa2 - fa1, 32'd50);
      repeat (120) @(negedge Clk);
      chk("fast_queue_drained", fq.size(), 32'd0);
      chk("fast_done_count", f_dones, 32'd2);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
      $fatal(1, "watchdog");
   end

endmodule
